// File: rtl/pps_tx_gen.sv
// Outgoing 1PPS pulse generator driven by the time-scale epoch strobe (pclk domain).
// Optional capture of the time counter at each pulse start when PPS_TIMESTAMP_EN is defined.
module pps_tx_gen #(
  parameter int EPOCH_WIDTH = 10,
  parameter int CNT_WIDTH   = 24
) (
  input  logic                   pclk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   arm,
  input  logic                   epoch_pulse,
  input  logic [EPOCH_WIDTH-1:0] period,
  input  logic [CNT_WIDTH-1:0]   phase_offset,
  input  logic [CNT_WIDTH-1:0]   width,
  input  logic                   polarity,
  output logic                   pps_out,
  output logic                   pps_strobe,
  output logic [31:0]            pps_count,
  output logic                   busy,
  output logic                   err
`ifdef PPS_TIMESTAMP_EN
  ,
  input  logic [63:0]            time_in,
  input  logic                   ts_rd,
  output logic [63:0]            pps_time,
  output logic                   pps_time_valid
`endif
);

  typedef enum logic [2:0] {IDLE, SYNC, RUN, DELAY, PULSE} state_t;

  state_t                 state, state_nx;
  logic [EPOCH_WIDTH-1:0] epoch_cnt, epoch_nx;
  logic [EPOCH_WIDTH-1:0] period_lat, period_nx;
  logic [CNT_WIDTH-1:0]   dly_cnt, dly_nx;
  logic [CNT_WIDTH-1:0]   pw_cnt, pw_nx;
  logic [CNT_WIDTH-1:0]   width_lat, width_nx;
  logic [31:0]            count_nx;
  logic                   active, active_nx;
  logic                   err_nx;
  logic                   act_set;
  logic                   epoch_last;
  logic                   trig;

  function automatic logic [EPOCH_WIDTH-1:0] sat_period(input logic [EPOCH_WIDTH-1:0] p);
    return (p == '0) ? EPOCH_WIDTH'(1) : p;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_width(input logic [CNT_WIDTH-1:0] w);
    return (w == '0) ? CNT_WIDTH'(1) : w;
  endfunction

  assign epoch_last = (epoch_cnt == period_lat - EPOCH_WIDTH'(1));
  assign trig       = epoch_pulse && ((state == SYNC) || ((state == RUN) && epoch_last));
  assign busy       = (state == DELAY) || (state == PULSE);
  assign pps_out    = active ^ polarity;

  always_comb begin
    state_nx  = state;
    epoch_nx  = epoch_cnt;
    period_nx = period_lat;
    dly_nx    = dly_cnt;
    pw_nx     = pw_cnt;
    width_nx  = width_lat;
    count_nx  = pps_count;
    active_nx = active;
    err_nx    = err;
    act_set   = 1'b0;
    if (!enable) begin
      state_nx  = IDLE;
      active_nx = 1'b0;
      epoch_nx  = '0;
    end else if (arm) begin
      state_nx  = SYNC;
      active_nx = 1'b0;
      epoch_nx  = '0;
      dly_nx    = '0;
      pw_nx     = '0;
      count_nx  = '0;
      err_nx    = 1'b0;
    end else begin
      case (state)
        IDLE, SYNC: ;
        RUN: begin
          if (epoch_pulse && !epoch_last) epoch_nx = epoch_cnt + EPOCH_WIDTH'(1);
        end
        DELAY, PULSE: begin
          // Epoch period keeps running; a trigger that lands here is dropped and flagged.
          if (epoch_pulse) begin
            if (epoch_last) begin
              err_nx    = 1'b1;
              epoch_nx  = '0;
              period_nx = sat_period(period);
            end else begin
              epoch_nx = epoch_cnt + EPOCH_WIDTH'(1);
            end
          end
          if (state == DELAY) begin
            if (dly_cnt == '0) begin
              active_nx = 1'b1;
              act_set   = 1'b1;
              pw_nx     = sat_width(width_lat);
              count_nx  = pps_count + 32'd1;
              state_nx  = PULSE;
            end else begin
              dly_nx = dly_cnt - CNT_WIDTH'(1);
            end
          end else begin
            if (pw_cnt <= CNT_WIDTH'(1)) begin
              active_nx = 1'b0;
              state_nx  = RUN;
            end else begin
              pw_nx = pw_cnt - CNT_WIDTH'(1);
            end
          end
        end
        default: state_nx = IDLE;
      endcase
      if (trig) begin
        epoch_nx  = '0;
        period_nx = sat_period(period);
        dly_nx    = phase_offset;
        width_nx  = width;
        state_nx  = DELAY;
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      epoch_cnt  <= '0;
      period_lat <= EPOCH_WIDTH'(1);
      dly_cnt    <= '0;
      pw_cnt     <= '0;
      width_lat  <= '0;
      pps_count  <= '0;
      active     <= 1'b0;
      pps_strobe <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      epoch_cnt  <= epoch_nx;
      period_lat <= period_nx;
      dly_cnt    <= dly_nx;
      pw_cnt     <= pw_nx;
      width_lat  <= width_nx;
      pps_count  <= count_nx;
      active     <= active_nx;
      pps_strobe <= act_set;
      err        <= err_nx;
    end
  end

`ifdef PPS_TIMESTAMP_EN
  // A new capture wins over a simultaneous read acknowledge.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      pps_time       <= '0;
      pps_time_valid <= 1'b0;
    end else if (act_set) begin
      pps_time       <= time_in;
      pps_time_valid <= 1'b1;
    end else if (ts_rd) begin
      pps_time_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pps_tx_gen.sv
// Directed bench for pps_tx_gen: expected pulses are queued when trigger epochs are driven
// and compared cycle by cycle against pps_out/pps_strobe/busy/err/pps_count.
module tb_pps_tx_gen;
  localparam int EW = 10;
  localparam int CW = 24;

  logic          pclk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          arm = 1'b0;
  logic          epoch_pulse = 1'b0;
  logic          polarity = 1'b0;
  logic [EW-1:0] period = '0;
  logic [CW-1:0] phase_offset = '0;
  logic [CW-1:0] width = '0;
  logic          pps_out, pps_strobe, busy, err;
  logic [31:0]   pps_count;
  int            cyc = 0;

`ifdef PPS_TIMESTAMP_EN
  localparam logic [63:0] TBASE = 64'h0123_4567_0000_0000;
  logic [63:0] time_in, pps_time;
  logic        pps_time_valid;
  logic        ts_rd = 1'b0;
  assign time_in = TBASE + 64'(cyc);
`endif

  pps_tx_gen #(.EPOCH_WIDTH(EW), .CNT_WIDTH(CW)) dut (
    .pclk(pclk), .reset_n(reset_n), .enable(enable), .arm(arm),
    .epoch_pulse(epoch_pulse), .period(period), .phase_offset(phase_offset),
    .width(width), .polarity(polarity), .pps_out(pps_out), .pps_strobe(pps_strobe),
    .pps_count(pps_count), .busy(busy), .err(err)
`ifdef PPS_TIMESTAMP_EN
    , .time_in(time_in), .ts_rd(ts_rd), .pps_time(pps_time), .pps_time_valid(pps_time_valid)
`endif
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    int trig;
    int start;
    int w;
    int cnt;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          pulse_num = 0;
  int          last_end = 0;
  int          last_start = 0;
  logic [31:0] exp_count = '0;
  logic        exp_err = 1'b0;
  bit          chk_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_cycle();
    logic e_act, e_stb, e_busy;
    e_act = 1'b0;
    e_stb = 1'b0;
    e_busy = 1'b0;
    while (q.size() > 0 && cyc >= q[0].start + q[0].w) void'(q.pop_front());
    if (q.size() > 0) begin
      if (cyc >= q[0].trig) e_busy = 1'b1;
      if (cyc >= q[0].start) begin
        e_act = 1'b1;
        e_stb = (cyc == q[0].start);
        if (e_stb) exp_count = 32'(q[0].cnt);
      end
    end
    check("pps_out", 64'(pps_out), 64'(e_act ^ polarity));
    check("pps_strobe", 64'(pps_strobe), 64'(e_stb));
    check("busy", 64'(busy), 64'(e_busy));
    check("err", 64'(err), 64'(exp_err));
    check("pps_count", 64'(pps_count), 64'(exp_count));
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
    if (chk_en) chk_cycle();
  endtask

  task automatic do_arm();
    exp_count = '0;
    exp_err = 1'b0;
    pulse_num = 0;
    last_end = 0;
    q.delete();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Drives n epochs spaced by 'spacing' cycles; every p-th epoch is a trigger candidate.
  task automatic run_epochs(input int n, input int spacing, input int p, input int off,
                            input int w, input bit allow);
    int   weff;
    exp_t e;
    weff = (w == 0) ? 1 : w;
    for (int k = 0; k < n; k++) begin
      if (allow && (k % p) == 0) begin
        if (cyc + 1 <= last_end) begin
          exp_err = 1'b1;
        end else begin
          pulse_num++;
          e.trig = cyc + 1;
          e.start = cyc + off + 2;
          e.w = weff;
          e.cnt = pulse_num;
          q.push_back(e);
          last_start = e.start;
          last_end = e.start + weff;
        end
      end
      epoch_pulse = 1'b1;
      tick();
      epoch_pulse = 1'b0;
      repeat (spacing - 1) tick();
    end
  endtask

  task automatic truncate_front();
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      e.w = cyc + 1 - e.start;
      q.push_front(e);
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_pps_out", 64'(pps_out), 64'd0);
    check("rst_strobe", 64'(pps_strobe), 64'd0);
    check("rst_count", 64'(pps_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    polarity = 1'b1;
    #1;
    check("rst_pps_out_pol1", 64'(pps_out), 64'd1);
    polarity = 1'b0;
    @(posedge pclk);
    #3;
    reset_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) tick();

    // Basic timing: period 4, offset 0, width 3, active-high
    enable = 1'b1;
    period = EW'(4);
    phase_offset = CW'(0);
    width = CW'(3);
    do_arm();
    run_epochs(9, 10, 4, 0, 3, 1'b1);
    check("basic_count", 64'(pps_count), 64'd3);

    // Phase offset 5, width 0 (one cycle), active-low
    polarity = 1'b1;
    period = EW'(1);
    phase_offset = CW'(5);
    width = CW'(0);
    do_arm();
    check("arm_clears_count", 64'(pps_count), 64'd0);
    run_epochs(3, 10, 1, 5, 0, 1'b1);

    // Overlap: second trigger lands inside a 15-cycle pulse
    polarity = 1'b0;
    phase_offset = CW'(0);
    width = CW'(15);
    do_arm();
    run_epochs(4, 10, 1, 0, 15, 1'b1);
    check("ovl_err", 64'(err), 64'd1);
    check("ovl_count", 64'(pps_count), 64'd2);
    repeat (20) tick();
    check("ovl_err_sticky", 64'(err), 64'd1);

    // Disable mid-pulse, then re-enable without arm
    period = EW'(4);
    width = CW'(8);
    do_arm();
    check("arm_clears_err", 64'(err), 64'd0);
    run_epochs(1, 5, 4, 0, 8, 1'b1);
    check("mid_pulse_out", 64'(pps_out), 64'd1);
    truncate_front();
    enable = 1'b0;
    tick();
    check("dis_out", 64'(pps_out), 64'd0);
    check("dis_busy", 64'(busy), 64'd0);
    check("dis_count_hold", 64'(pps_count), 64'd1);
    repeat (3) tick();
    enable = 1'b1;
    run_epochs(6, 10, 4, 0, 8, 1'b0);
    check("reen_no_pulse", 64'(pps_count), 64'd1);

    // period 0 behaves as 1: pulse on every epoch
    period = EW'(0);
    phase_offset = CW'(1);
    width = CW'(2);
    do_arm();
    run_epochs(4, 10, 1, 1, 2, 1'b1);
    check("p0_count", 64'(pps_count), 64'd4);

    // Asynchronous reset in the middle of an active-low pulse
    polarity = 1'b1;
    period = EW'(1);
    phase_offset = CW'(0);
    width = CW'(6);
    do_arm();
    run_epochs(1, 4, 1, 0, 6, 1'b1);
    check("pre_rst_out", 64'(pps_out), 64'd0);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_out", 64'(pps_out), 64'd1);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_count", 64'(pps_count), 64'd0);
    chk_en = 1'b0;
    q.delete();
    exp_count = '0;
    exp_err = 1'b0;
    last_end = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) tick();

`ifdef PPS_TIMESTAMP_EN
    // Timestamp capture, overwrite while valid, read acknowledge
    check("ts_valid_init", 64'(pps_time_valid), 64'd0);
    check("ts_time_init", pps_time, 64'd0);
    polarity = 1'b0;
    phase_offset = CW'(3);
    width = CW'(2);
    do_arm();
    run_epochs(2, 12, 1, 3, 2, 1'b1);
    check("ts_valid", 64'(pps_time_valid), 64'd1);
    check("ts_time", pps_time, TBASE + 64'(last_start - 1));
    ts_rd = 1'b1;
    tick();
    ts_rd = 1'b0;
    check("ts_valid_cleared", 64'(pps_time_valid), 64'd0);
    check("ts_time_hold", pps_time, TBASE + 64'(last_start - 1));
`endif

    enable = 1'b0;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
